// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width derived from the operand width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A single-bit operand still needs a one-bit counter to hold index 0.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, framed by a start/done handshake.
// Results are held from the done cycle until the next accepted start.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned          CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]      CntLast = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              bin_q, bin_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              borrow_q, borrow_d;
    logic              overflow_q, overflow_d;

    logic              bit_d;
    logic              bit_bout;
    logic [WIDTH:0]    diff_shift;

    full_subtractor u_full_subtractor (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // New result bit enters from the MSB side; works for WIDTH == 1 as well.
    assign diff_shift = {bit_d, diff_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = diff_shift[WIDTH:1];
                bin_d  = bit_bout;
                if (cnt_q == CntLast) begin
                    state_d    = StDone;
                    borrow_d   = bit_bout;
                    // Signed overflow only when operand signs differ and the result sign flips.
                    overflow_d = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            bin_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule
